// File: rtl/nibble_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract sequencer.
package nibble_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder built from full-adder equations.
module ripple_adder (
  output logic       co,
  output logic [3:0] SUM,
  input  logic       ci,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  always_comb begin
    logic w_c;
    w_c = ci;
    SUM = '0;
    for (int i = 0; i < 4; i++) begin
      SUM[i] = A[i] ^ B[i] ^ w_c;
      w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit add/sub done one nibble per cycle through a shared 4-bit adder, LSB first.
// Result valid NSLICE edges after accept; held in DONE until out_ready, no new request taken meanwhile.
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_w(NSLICE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW-1:0]      r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_sum_sl;
  logic               w_co;
  logic               w_last;

  assign w_a_sl = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_sl = r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last = (r_idx == IW'(NSLICE - 1));

  ripple_adder u_adder (
    .co  (w_co),
    .SUM (w_sum_sl),
    .ci  (r_carry),
    .A   (w_a_sl),
    .B   (w_b_sl)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: invert B here, the +1 rides in as the first carry.
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= w_sum_sl;
          r_carry                          <= w_co;
          if (w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_sum_sl[SLICE_W-1] != r_a[WIDTH-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_co    = r_carry;
  assign out_ovf   = r_ovf;

endmodule
